// File: rtl/div_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// div_bus_master_pkg
// Purpose : shared constants for the divider peripheral bus initiator.
//           Holds the peripheral register map, the initiator FSM state
//           encodings and a small helper that classifies states.
// Contents: REG_* register addresses, S_* state codes, inTimedPhase().
// ---------------------------------------------------------------------------
package div_bus_master_pkg;

    // Divider peripheral register map (byte addresses on the cs/addr bus)
    localparam int unsigned REG_A      = 'h04;
    localparam int unsigned REG_B      = 'h08;
    localparam int unsigned REG_INIT   = 'h0C;
    localparam int unsigned REG_RESULT = 'h10;
    localparam int unsigned REG_DONE   = 'h14;

    // Initiator FSM state encodings
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_WR_A  = 4'd1;
    localparam logic [3:0] S_WR_B  = 4'd2;
    localparam logic [3:0] S_INIT1 = 4'd3;
    localparam logic [3:0] S_INIT0 = 4'd4;
    localparam logic [3:0] S_GAP   = 4'd5;
    localparam logic [3:0] S_DREQ  = 4'd6;
    localparam logic [3:0] S_DCAP  = 4'd7;
    localparam logic [3:0] S_RREQ  = 4'd8;
    localparam logic [3:0] S_RCAP  = 4'd9;
    localparam logic [3:0] S_FIN   = 4'd10;

    // True for the states between the init pulse and the end of the
    // operation, i.e. the window in which the timeout counter runs.
    function automatic logic inTimedPhase(input logic [3:0] state);
        return (state == S_GAP)  || (state == S_DREQ) || (state == S_DCAP) ||
               (state == S_RREQ) || (state == S_RCAP);
    endfunction

endpackage

// File: rtl/div_bus_master.sv
// ---------------------------------------------------------------------------
// div_bus_master
// Purpose : bus initiator for the memory-mapped divider peripheral. On an
//           accepted host start it writes A and B, pulses INIT, polls DONE
//           and reads RESULT, presenting a simple start/busy/done interface.
// Ports   :
//   clk, rst           clock, synchronous active-high reset
//   start, op_a, op_b  host request and operands (sampled in IDLE only)
//   busy, done         operation in flight / one-cycle completion pulse
//   result             RESULT register value, held until next accepted start
//   err_timeout        set with done when the peripheral never reported done
//   cs, addr, rd, wr   peripheral bus controls (all registered)
//   bus_wdata          write data to the peripheral
//   bus_rdata          peripheral read data (one-cycle read latency)
// ---------------------------------------------------------------------------
module div_bus_master
    import div_bus_master_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 5,
    parameter int START_GAP = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err_timeout,
    output logic              cs,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (START_GAP > 1) ? $clog2(START_GAP) : 1;

    logic [3:0]        r_state;
    logic [DATA_W-1:0] r_opB;
    logic [GW-1:0]     r_gapCnt;
    logic [TW-1:0]     r_timeCnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_err;
    logic              r_cs;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_timedOut;

    assign w_timedOut = (r_timeCnt >= TW'(TIMEOUT));

    // Main sequencer. Bus outputs are registered: whenever the FSM moves
    // into a bus state, the strobes/address/data for that state are loaded
    // on the same edge so they are visible for exactly that state's cycle.
    // Strobes and done default low each cycle and are only raised on entry
    // to a state that drives them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opB    <= '0;
            r_gapCnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cs     <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_cs   <= 1'b0;
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opB   <= op_b;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_WR_A;
                        r_cs    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= ADDR_W'(REG_A);
                        r_wdata <= op_a;
                    end
                end
                S_WR_A: begin
                    r_state <= S_WR_B;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_W'(REG_B);
                    r_wdata <= r_opB;
                end
                S_WR_B: begin
                    r_state <= S_INIT1;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_W'(REG_INIT);
                    r_wdata <= DATA_W'(1);
                end
                S_INIT1: begin
                    r_state <= S_INIT0;
                    r_cs    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_addr  <= ADDR_W'(REG_INIT);
                    r_wdata <= '0;
                end
                S_INIT0: begin
                    // The gap hides a stale DONE left over from the previous
                    // operation; a zero-length gap goes straight to polling.
                    if (START_GAP == 0) begin
                        r_state <= S_DREQ;
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_W'(REG_DONE);
                    end else begin
                        r_state  <= S_GAP;
                        r_gapCnt <= '0;
                    end
                end
                S_GAP: begin
                    if (r_gapCnt == GW'(START_GAP - 1)) begin
                        r_state <= S_DREQ;
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_W'(REG_DONE);
                    end else begin
                        r_gapCnt <= r_gapCnt + GW'(1);
                    end
                end
                S_DREQ: begin
                    r_state <= S_DCAP;
                end
                S_DCAP: begin
                    if (bus_rdata[0]) begin
                        r_state <= S_RREQ;
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_W'(REG_RESULT);
                    end else if (w_timedOut) begin
                        r_state  <= S_FIN;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_state <= S_DREQ;
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_W'(REG_DONE);
                    end
                end
                S_RREQ: begin
                    r_state <= S_RCAP;
                end
                S_RCAP: begin
                    r_result <= bus_rdata;
                    r_state  <= S_FIN;
                    r_done   <= 1'b1;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Timeout counter: zeroed while the init pulse falls, then counts every
    // cycle of the gap/poll/read phase, saturating so it can never wrap
    // back below the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeCnt <= '0;
        end else if (r_state == S_INIT0) begin
            r_timeCnt <= '0;
        end else if (inTimedPhase(r_state) && !w_timedOut) begin
            r_timeCnt <= r_timeCnt + TW'(1);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign err_timeout = r_err;
    assign cs          = r_cs;
    assign rd          = r_rd;
    assign wr          = r_wr;
    assign addr        = r_addr;
    assign bus_wdata   = r_wdata;

endmodule

// File: tb/tb_div_bus_master.sv
// ---------------------------------------------------------------------------
// tb_div_bus_master
// Purpose : drives div_bus_master against a behavioural divider peripheral
//           and checks every completed operation against expectations
//           queued when each start is issued.
// ---------------------------------------------------------------------------
module tb_div_bus_master;
    import div_bus_master_pkg::*;

    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int GAPC = 2;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          errTimeout;
    logic          cs;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] busWdata;
    logic [DW-1:0] busRdata;

    always #5 clk = ~clk;

    div_bus_master #(
        .DATA_W(DW), .ADDR_W(AW), .START_GAP(GAPC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(opA), .op_b(opB),
        .busy(busy), .done(done), .result(result), .err_timeout(errTimeout),
        .cs(cs), .addr(addr), .rd(rd), .wr(wr), .bus_wdata(busWdata),
        .bus_rdata(busRdata)
    );

    // Behavioural divider peripheral. Mode 0 reports done a programmable
    // number of cycles after INIT falls; mode 1 has done stuck high and
    // mode 2 has done stuck low.
    int            periphMode;
    int            periphLatency;
    logic [DW-1:0] pA, pB, pRes;
    logic          pDone, pInit;
    int            pCount;
    logic          doneBit;

    assign doneBit = (periphMode == 1) ? 1'b1 : (periphMode == 2) ? 1'b0 : pDone;

    always @(posedge clk) begin
        if (rst) begin
            pA <= '0; pB <= '0; pRes <= '0; pDone <= 1'b0; pInit <= 1'b0;
            pCount <= -1; busRdata <= '0;
        end else begin
            if (pCount > 0) pCount <= pCount - 1;
            else if (pCount == 0) begin pDone <= 1'b1; pCount <= -1; end
            if (cs && wr) begin
                if (int'(addr) == int'(REG_A)) pA <= busWdata;
                else if (int'(addr) == int'(REG_B)) pB <= busWdata;
                else if (int'(addr) == int'(REG_INIT)) begin
                    pInit <= busWdata[0];
                    if (busWdata[0]) begin
                        pDone <= 1'b0; pCount <= -1;
                    end else if (pInit) begin
                        pRes   <= (pB == '0) ? 16'hFFFF : pA / pB;
                        pCount <= periphLatency;
                    end
                end
            end
            if (cs && rd) begin
                if (int'(addr) == int'(REG_RESULT)) busRdata <= pRes;
                else if (int'(addr) == int'(REG_DONE)) busRdata <= {15'd0, doneBit};
                else busRdata <= '0;
            end
        end
    end

    // Scoreboard state
    typedef struct {
        int a; int b; int res; int err; int startCyc; int expLat;
    } expItem_t;
    typedef struct { int isWr; int addr; int data; } busEv_t;

    expItem_t expQ[$];
    busEv_t   busLog[$];
    int       cycleCnt = 0;
    int       doneCount = 0;
    int       pushedCount = 0;
    int       checkCount = 0;
    int       errCount = 0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    function automatic int refDiv(input int a, input int b);
        return (b == 0) ? 65535 : a / b;
    endfunction

    // Compare one completed operation against the oldest expectation and
    // against the bus traffic recorded since the previous completion.
    task automatic checkOutput();
        expItem_t it;
        int nWr, nDoneRd, nResRd, nOther, lat;
        int wAddr[4];
        int wData[4];
        int expAddr[4];
        int expData[4];
        doneCount++;
        if (expQ.size() == 0) begin
            check("unexpected_done", 1, 0);
            busLog.delete();
            return;
        end
        it = expQ.pop_front();
        check("result", int'(result), it.res);
        check("err_timeout", int'(errTimeout), it.err);
        check("busy_with_done", int'(busy), 1);
        nWr = 0; nDoneRd = 0; nResRd = 0; nOther = 0;
        foreach (busLog[i]) begin
            if (busLog[i].isWr != 0) begin
                if (nWr < 4) begin wAddr[nWr] = busLog[i].addr; wData[nWr] = busLog[i].data; end
                nWr++;
            end else if (busLog[i].addr == int'(REG_DONE)) nDoneRd++;
            else if (busLog[i].addr == int'(REG_RESULT)) nResRd++;
            else nOther++;
        end
        check("write_count", nWr, 4);
        expAddr = '{int'(REG_A), int'(REG_B), int'(REG_INIT), int'(REG_INIT)};
        expData = '{it.a, it.b, 1, 0};
        for (int k = 0; k < 4 && k < nWr; k++) begin
            check($sformatf("write%0d_addr", k), wAddr[k], expAddr[k]);
            check($sformatf("write%0d_data", k), wData[k], expData[k]);
        end
        check("stray_reads", nOther, 0);
        check("result_reads", nResRd, (it.err != 0) ? 0 : 1);
        if (it.err == 0 && busLog.size() > 0)
            check("result_read_last", busLog[busLog.size()-1].addr, int'(REG_RESULT));
        lat = cycleCnt - it.startCyc;
        if (it.expLat >= 0) begin
            check("latency", lat, it.expLat);
            check("done_reads", nDoneRd, 1);
        end else if (it.err == 0) begin
            check("latency_vs_polls", lat, 8 + GAPC + 2 * (nDoneRd - 1));
        end
        busLog.delete();
    endtask

    // Monitor: records bus cycles and checks each done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cs) begin
                busEv_t ev;
                ev.isWr = wr ? 1 : 0;
                ev.addr = int'(addr);
                ev.data = wr ? int'(busWdata) : 0;
                busLog.push_back(ev);
            end
            if (!rst && done) checkOutput();
        end
    end

    task automatic pushExp(input int a, input int b, input int err, input int expLat);
        expItem_t it;
        it.a = a; it.b = b; it.err = err;
        it.res = (err != 0) ? 0 : refDiv(a, b);
        it.startCyc = cycleCnt;
        it.expLat = expLat;
        expQ.push_back(it);
        pushedCount++;
    endtask

    // Issue a start from IDLE, hold it for holdCycles edges, then scramble
    // the operands so only the latched values can produce the right answer.
    task automatic applyStimulus(input int a, input int b, input int holdCycles,
                                 input int err, input int expLat);
        @(negedge clk);
        start = 1'b1; opA = DW'(a); opB = DW'(b);
        @(posedge clk); #1;
        pushExp(a, b, err, expLat);
        repeat (holdCycles - 1) @(posedge clk);
        #1;
        start = 1'b0;
        opA = DW'($urandom); opB = DW'($urandom);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (doneCount >= pushedCount) return;
        end
        check("done_wait_timeout", doneCount, pushedCount);
        expQ.delete();
        pushedCount = doneCount;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opA = '0; opB = '0;
        periphMode = 0; periphLatency = 3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", int'(cs), 0);
        check("rst_rd", int'(rd), 0);
        check("rst_wr", int'(wr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(errTimeout), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_wdata", int'(busWdata), 0);
        check("rst_result", int'(result), 0);
        @(negedge clk); rst = 1'b0;

        $display("[TB] basic 100/7");
        applyStimulus(100, 7, 1, 0, -1);
        waitDone();

        $display("[TB] done stuck high");
        periphMode = 1;
        applyStimulus(50, 5, 1, 0, 8 + GAPC);
        waitDone();

        $display("[TB] done stuck low, timeout");
        periphMode = 2;
        applyStimulus(1234, 2, 1, 1, -1);
        waitDone();
        periphMode = 0;
        applyStimulus(40, 8, 1, 0, -1);
        waitDone();

        $display("[TB] held start and start while busy");
        applyStimulus(1000, 10, 3, 0, -1);
        @(negedge clk); start = 1'b1; opA = 16'd500; opB = 16'd5;
        @(negedge clk); start = 1'b0;
        waitDone();
        repeat (20) @(posedge clk);
        #1;
        check("no_second_op", int'(busy), 0);

        $display("[TB] reset while polling");
        periphMode = 2;
        applyStimulus(9, 3, 1, 0, -1);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cs", int'(cs), 0);
        check("midrst_rd", int'(rd), 0);
        check("midrst_wr", int'(wr), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_result", int'(result), 0);
        expQ.delete();
        pushedCount = doneCount;
        @(negedge clk); rst = 1'b0;
        busLog.delete();
        periphMode = 0;
        applyStimulus(9, 3, 1, 0, -1);
        waitDone();

        $display("[TB] back-to-back");
        applyStimulus(65535, 1, 1, 0, -1);
        waitDone();
        start = 1'b1; opA = 16'd1; opB = 16'd2;
        @(posedge clk); #1;
        check("fin_start_ignored", int'(busy), 0);
        @(posedge clk); #1;
        pushExp(1, 2, 0, -1);
        check("b2b_accepted", int'(busy), 1);
        start = 1'b0; opA = DW'($urandom); opB = DW'($urandom);
        waitDone();

        $display("[TB] random operations");
        for (int n = 0; n < 12; n++) begin
            int a, b;
            a = int'($urandom_range(65535, 0));
            b = (n == 5) ? 0 : int'($urandom_range(300, 1));
            periphLatency = int'($urandom_range(6, 0));
            applyStimulus(a, b, 1, 0, -1);
            waitDone();
        end

        repeat (5) @(posedge clk);
        check("queue_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
